// File: rtl/mem_serial_pkg.sv
// MEM stage shared definitions: memory op codes, FSM states, op decode helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package mem_serial_pkg;

    typedef logic [3:0] mem_op_bus_t;

    localparam mem_op_bus_t MEMOP_NONE = 4'd0;
    localparam mem_op_bus_t MEMOP_LB   = 4'd1;
    localparam mem_op_bus_t MEMOP_LH   = 4'd2;
    localparam mem_op_bus_t MEMOP_LW   = 4'd3;
    localparam mem_op_bus_t MEMOP_LBU  = 4'd4;
    localparam mem_op_bus_t MEMOP_LHU  = 4'd5;
    localparam mem_op_bus_t MEMOP_SB   = 4'd6;
    localparam mem_op_bus_t MEMOP_SH   = 4'd7;
    localparam mem_op_bus_t MEMOP_SW   = 4'd8;

    typedef enum logic [1:0] {
        MEMST_IDLE  = 2'd0,
        MEMST_LOAD  = 2'd1,
        MEMST_STORE = 2'd2
    } memst_e;

    // Number of bytes moved by an op; 0 for non-memory and unknown codes.
    function automatic logic [2:0] memop_width(input mem_op_bus_t op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: memop_width = 3'd1;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: memop_width = 3'd2;
            MEMOP_LW, MEMOP_SW:            memop_width = 3'd4;
            default:                       memop_width = 3'd0;
        endcase
    endfunction

    function automatic logic memop_is_load(input mem_op_bus_t op);
        memop_is_load = (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
                        (op == MEMOP_LBU) || (op == MEMOP_LHU);
    endfunction

    function automatic logic memop_is_store(input mem_op_bus_t op);
        memop_is_store = (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
    function automatic logic memop_misaligned(input mem_op_bus_t op, input logic [1:0] a);
        case (memop_width(op))
            3'd2:    memop_misaligned = a[0];
            3'd4:    memop_misaligned = (a != 2'b00);
            default: memop_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_serial_ldext.sv
// Load extension: picks byte/half/word from 4 assembled little-endian bytes and sign/zero extends.
// Latency: combinational.
// Backpressure: none.
module mem_ldext
    import mem_serial_pkg::*;
(
    input  logic [31:0]  i_bytes,
    input  mem_op_bus_t  i_memop,
    output logic [31:0]  o_data
);

    // Extension selected by op; LW and anything else pass the word unchanged.
    always_comb begin
        o_data = i_bytes;
        case (i_memop)
            MEMOP_LB:  o_data = {{24{i_bytes[7]}}, i_bytes[7:0]};
            MEMOP_LBU: o_data = {24'd0, i_bytes[7:0]};
            MEMOP_LH:  o_data = {{16{i_bytes[15]}}, i_bytes[15:0]};
            MEMOP_LHU: o_data = {16'd0, i_bytes[15:0]};
            default:   o_data = i_bytes;
        endcase
    end

endmodule

// File: rtl/mem_serial.sv
// MEM stage: ALU pass-through in 1 cycle; loads/stores run byte-serially on a byte-wide sync RAM.
// Latency: NONE 1 cycle, load n+2, store n+1 cycles (n = access bytes).
// Backpressure: stallreq_o holds upstream until the access drains. Optional MEM_MISALIGN_TRAP_EN adds misalign_o.
module mem_serial
    import mem_serial_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        memop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    input  logic [7:0]        ram_din_i,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    output logic              stallreq_o,
    output logic              wb_valid_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    memst_e            r_state;
    memst_e            w_state_nxt;
    logic [2:0]        r_cnt;
    mem_op_bus_t       r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [4:0]        r_wd;
    logic              r_wreg;
    logic [31:0]       r_bytes;

    logic [2:0]        w_n;
    logic              w_misalign;
    logic              w_is_mem;
    logic              w_start;
    logic              w_stall;
    logic [2:0]        w_lane_full;
    logic [31:0]       w_bytes_cur;
    logic [31:0]       w_ext;
    logic [ADDR_W-1:0] w_next_a;
    logic [7:0]        w_sbyte;
    logic              w_unused_addr;

    assign w_unused_addr = ^mem_addr_i[31:ADDR_W];

    assign w_n      = memop_width(r_op);
    assign w_is_mem = memop_is_load(memop_i) || memop_is_store(memop_i);
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = ex_valid_i && w_is_mem && memop_misaligned(memop_i, mem_addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_start  = ex_valid_i && w_is_mem && !w_misalign;

    // Byte k of the access sits at r_addr + k, wrapping at the RAM size.
    assign w_next_a = r_addr + {{(ADDR_W-3){1'b0}}, r_cnt};
    assign w_sbyte  = r_data[{r_cnt[1:0], 3'b000} +: 8];

    // Read data for lane k arrives two LOAD cycles after the counter starts.
    assign w_lane_full = r_cnt - 3'd2;

    // Merge the byte arriving this cycle so the last lane reaches writeback without an extra cycle.
    always_comb begin
        w_bytes_cur = r_bytes;
        if ((r_state == MEMST_LOAD) && (r_cnt >= 3'd2))
            w_bytes_cur[{w_lane_full[1:0], 3'b000} +: 8] = ram_din_i;
    end

    mem_ldext u_ldext (
        .i_bytes (w_bytes_cur),
        .i_memop (r_op),
        .o_data  (w_ext)
    );

    // Next state and stall request; stall drops in the final cycle so upstream advances in step.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            MEMST_IDLE: begin
                if (w_start) begin
                    w_stall     = 1'b1;
                    w_state_nxt = memop_is_load(memop_i) ? MEMST_LOAD : MEMST_STORE;
                end
            end
            MEMST_LOAD: begin
                w_stall = (r_cnt <= w_n);
                if (r_cnt == (w_n + 3'd1))
                    w_state_nxt = MEMST_IDLE;
            end
            MEMST_STORE: begin
                w_stall = (r_cnt < w_n);
                if (r_cnt == w_n)
                    w_state_nxt = MEMST_IDLE;
            end
            default: w_state_nxt = MEMST_IDLE;
        endcase
    end

    // Stall is forced low while reset is asserted so every output reads 0 in reset.
    assign stallreq_o = rst & w_stall;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= MEMST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Datapath: access latching, RAM drive, byte capture and writeback registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 3'd0;
            r_op       <= MEMOP_NONE;
            r_addr     <= '0;
            r_data     <= 32'd0;
            r_wd       <= 5'd0;
            r_wreg     <= 1'b0;
            r_bytes    <= 32'd0;
            ram_a_o    <= '0;
            ram_dout_o <= 8'd0;
            ram_wr_o   <= 1'b0;
            wb_valid_o <= 1'b0;
            wd_o       <= 5'd0;
            wreg_o     <= 1'b0;
            wdata_o    <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
            wreg_o     <= 1'b0;
            ram_wr_o   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (r_state)
                MEMST_IDLE: begin
                    r_cnt <= 3'd1;
                    if (w_misalign) begin
                        wb_valid_o <= 1'b1;
                        wd_o       <= wd_i;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_o <= 1'b1;
`ifndef SYNTHESIS
                        $display("mem_serial: misaligned access op=%0d addr=%h", memop_i, mem_addr_i);
`endif
`endif
                    end else if (w_start) begin
                        r_op    <= memop_i;
                        r_addr  <= mem_addr_i[ADDR_W-1:0];
                        r_data  <= mem_data_i;
                        r_wd    <= wd_i;
                        r_wreg  <= wreg_i;
                        r_bytes <= 32'd0;
                        ram_a_o <= mem_addr_i[ADDR_W-1:0];
                        if (memop_is_store(memop_i)) begin
                            ram_wr_o   <= 1'b1;
                            ram_dout_o <= mem_data_i[7:0];
                        end
                    end else if (ex_valid_i) begin
                        wb_valid_o <= 1'b1;
                        wd_o       <= wd_i;
                        wreg_o     <= wreg_i;
                        wdata_o    <= wdata_i;
                    end
                end
                MEMST_LOAD: begin
                    r_cnt   <= r_cnt + 3'd1;
                    r_bytes <= w_bytes_cur;
                    if (r_cnt < w_n)
                        ram_a_o <= w_next_a;
                    if (r_cnt == (w_n + 3'd1)) begin
                        wb_valid_o <= 1'b1;
                        wd_o       <= r_wd;
                        wreg_o     <= r_wreg;
                        wdata_o    <= w_ext;
                    end
                end
                MEMST_STORE: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt < w_n) begin
                        ram_a_o    <= w_next_a;
                        ram_dout_o <= w_sbyte;
                        ram_wr_o   <= 1'b1;
                    end else begin
                        wb_valid_o <= 1'b1;
                        wd_o       <= r_wd;
                    end
                end
                default: r_cnt <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_serial.sv
// Bench for mem_serial: sync byte RAM model, directed cases then random ops against a reference model.
// Latency: n/a.
// Backpressure: follows stallreq_o, releasing ex_valid_i once the stall drops.
module tb_mem_serial;
    import mem_serial_pkg::*;

    localparam int          AW    = 17;
    localparam logic [31:0] AMASK = 32'h0001_FFFF;

    logic          clk;
    logic          rst;
    logic          ex_valid_i;
    logic [4:0]    wd_i;
    logic          wreg_i;
    logic [31:0]   wdata_i;
    logic [3:0]    memop_i;
    logic [31:0]   mem_addr_i;
    logic [31:0]   mem_data_i;
    logic [7:0]    ram_din_i;
    logic [AW-1:0] ram_a_o;
    logic [7:0]    ram_dout_o;
    logic          ram_wr_o;
    logic          stallreq_o;
    logic          wb_valid_o;
    logic [4:0]    wd_o;
    logic          wreg_o;
    logic [31:0]   wdata_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic          misalign_o;
`endif

    mem_serial #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid_i (ex_valid_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .memop_i    (memop_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .ram_din_i  (ram_din_i),
        .ram_a_o    (ram_a_o),
        .ram_dout_o (ram_dout_o),
        .ram_wr_o   (ram_wr_o),
        .stallreq_o (stallreq_o),
        .wb_valid_o (wb_valid_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_o (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears the cycle after the address; also accepts bench pokes.
    logic [7:0]    ram [0:(1<<AW)-1];
    bit            ram_init;
    logic          pk_en;
    logic [AW-1:0] pk_a;
    logic [7:0]    pk_d;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= 8'($urandom);
            ram_init <= 1'b1;
        end else begin
            if (pk_en)    ram[pk_a]    <= pk_d;
            if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;
        end
        ram_din_i <= ram[ram_a_o];
    end

    int n_chk;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pk_en = 1'b1;
        pk_a  = a[AW-1:0];
        pk_d  = d;
        @(posedge clk);
        #1 pk_en = 1'b0;
    endtask

    function automatic int op_width(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    // Expected load result computed arithmetically from the RAM contents.
    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
        int b [4];
        int v;
        for (int k = 0; k < 4; k++) b[k] = int'(ram[(addr + 32'(k)) & AMASK]);
        case (op)
            4'd1: begin v = b[0]; if (v > 127) v = v - 256; end
            4'd4: v = b[0];
            4'd2: begin v = b[0] + 256 * b[1]; if (v > 32767) v = v - 65536; end
            4'd5: v = b[0] + 256 * b[1];
            default: return {8'(b[3]), 8'(b[2]), 8'(b[1]), 8'(b[0])};
        endcase
        return 32'(v);
    endfunction

    // Issue one instruction, follow it cycle by cycle and compare against the reference.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] wdat);
        int          n;
        bit          ld;
        bit          st;
        int          exp_stall;
        int          exp_wb;
        int          stall_cnt;
        int          wb_cyc;
        int          wr_bad;
        bit          rel;
        logic [31:0] exp_ld;
        logic [7:0]  after_byte;
        ld = op_load(op);
        st = op_store(op);
        n  = op_width(op);
        exp_stall = ld ? n + 1 : (st ? n : 0);
        exp_wb    = ld ? n + 2 : (st ? n + 1 : 1);
        exp_ld    = ref_load(op, addr);
        after_byte = ram[(addr + 32'(n)) & AMASK];
        stall_cnt = 0;
        wb_cyc    = -1;
        wr_bad    = 0;
        rel       = 1'b0;
        @(posedge clk);
        #1;
        ex_valid_i = 1'b1;
        memop_i    = op;
        mem_addr_i = addr;
        mem_data_i = sdata;
        wd_i       = wd;
        wreg_i     = wreg;
        wdata_i    = wdat;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (stallreq_o) stall_cnt++;
            if (ld && c >= 1 && c <= n)
                check("ld_addr", 32'(ram_a_o), (addr + 32'(c - 1)) & AMASK);
            if (st && c >= 1 && c <= n) begin
                check("st_wr", 32'(ram_wr_o), 32'd1);
                check("st_addr", 32'(ram_a_o), (addr + 32'(c - 1)) & AMASK);
                check("st_byte", 32'(ram_dout_o), (sdata >> (8 * (c - 1))) & 32'hFF);
            end else if (ram_wr_o) begin
                wr_bad++;
            end
            if (wb_valid_o) begin
                wb_cyc = c;
                break;
            end
            if (!stallreq_o) rel = 1'b1;
            @(posedge clk);
            #1;
            if (rel) ex_valid_i = 1'b0;
        end
        check("wb_cycle", 32'(wb_cyc), 32'(exp_wb));
        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        check("stray_wr", 32'(wr_bad), 32'd0);
        if (wb_cyc >= 0) begin
            check("wd", 32'(wd_o), 32'(wd));
            check("wreg", 32'(wreg_o), st ? 32'd0 : 32'(wreg));
            if (ld)       check("ld_data", wdata_o, exp_ld);
            else if (!st) check("alu_data", wdata_o, wdat);
        end
        if (st) begin
            for (int k = 0; k < n; k++)
                check("st_mem", 32'(ram[(addr + 32'(k)) & AMASK]), (sdata >> (8 * k)) & 32'hFF);
            check("st_neighbour", 32'(ram[(addr + 32'(n)) & AMASK]), 32'(after_byte));
        end
        @(negedge clk);
        check("wb_pulse", 32'(wb_valid_o), 32'd0);
    endtask

    initial begin
        bit seen_wb;
        bit seen_wr;
        n_chk = 0;
        n_pass = 0;
        pk_en = 1'b0;
        pk_a = '0;
        pk_d = 8'd0;
        rst = 1'b0;
        ex_valid_i = 1'b0;
        wd_i = 5'd0;
        wreg_i = 1'b0;
        wdata_i = 32'd0;
        memop_i = 4'd0;
        mem_addr_i = 32'd0;
        mem_data_i = 32'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_wr", 32'(ram_wr_o), 32'd0);
        check("rst_wb", 32'(wb_valid_o), 32'd0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_addr", 32'(ram_a_o), 32'd0);
        check("rst_dout", 32'(ram_dout_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_wd", 32'(wd_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Idle with no instruction.
        repeat (2) @(negedge clk);
        check("idle_wb", 32'(wb_valid_o), 32'd0);
        check("idle_stall", 32'(stallreq_o), 32'd0);

        // Directed cases.
        run_txn(MEMOP_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234_5678);
        poke(32'h100, 8'h78);
        poke(32'h101, 8'h56);
        poke(32'h102, 8'h34);
        poke(32'h103, 8'h12);
        run_txn(MEMOP_LW, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0);
        check("lw_value", wdata_o, 32'h1234_5678);
        poke(32'h200, 8'h80);
        run_txn(MEMOP_LB, 32'h200, 32'h0, 5'd8, 1'b1, 32'h0);
        check("lb_value", wdata_o, 32'hFFFF_FF80);
        run_txn(MEMOP_LBU, 32'h200, 32'h0, 5'd9, 1'b1, 32'h0);
        check("lbu_value", wdata_o, 32'h0000_0080);
        poke(32'h300, 8'h00);
        poke(32'h301, 8'h80);
        run_txn(MEMOP_LH, 32'h300, 32'h0, 5'd10, 1'b1, 32'h0);
        check("lh_value", wdata_o, 32'hFFFF_8000);
        run_txn(MEMOP_SH, 32'h1FFFF, 32'hAABB_CCDD, 5'd11, 1'b1, 32'h0);
        check("sh_wrap_hi", 32'(ram[17'h1FFFF]), 32'hDD);
        check("sh_wrap_lo", 32'(ram[17'h00000]), 32'hCC);

        // Reset in the middle of a store.
        @(posedge clk);
        #1;
        ex_valid_i = 1'b1;
        memop_i    = MEMOP_SW;
        mem_addr_i = 32'h400;
        mem_data_i = 32'h1122_3344;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_wr", 32'(ram_wr_o), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_wr", 32'(ram_wr_o), 32'd0);
        check("mid_rst_stall", 32'(stallreq_o), 32'd0);
        check("mid_rst_wb", 32'(wb_valid_o), 32'd0);
        ex_valid_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        seen_wb = 1'b0;
        seen_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_valid_o) seen_wb = 1'b1;
            if (ram_wr_o)   seen_wr = 1'b1;
        end
        check("post_rst_wb", 32'(seen_wb), 32'd0);
        check("post_rst_wr", 32'(seen_wr), 32'd0);
        run_txn(MEMOP_NONE, 32'h0, 32'h0, 5'd3, 1'b1, 32'hCAFE_F00D);

        // Random mix, including unknown op codes.
        for (int t = 0; t < 40; t++) begin
            run_txn(4'($urandom_range(0, 15)), $urandom, $urandom,
                    5'($urandom), 1'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
